// File: rtl/uart_pkg.sv
// Shared types and constants for the decimal telemetry UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_WAIT
  } msg_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_dec_tx_if.sv
// Value handshake plus line/status outputs of the decimal UART transmitter.
interface uart_dec_tx_if #(
  parameter int VAL_W = 7
);
  logic             valid;
  logic [VAL_W-1:0] value;
  logic             ready;
  logic             busy;
  logic             tx;
  logic             done;

  modport master (output valid, value, input ready, busy, tx, done);
  modport slave  (input valid, value, output ready, busy, tx, done);
endinterface

// File: rtl/uart_byte_tx.sv
// One-byte UART frame serialiser: start, 8 data bits LSB first, optional parity, stop bits.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int HAS_PAR    = (PARITY != int'(PAR_NONE)) ? 1 : 0;
  localparam int FRAME_BITS = 10 + HAS_PAR + (STOP_BITS - 1);
  localparam int CNT_W      = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame;
  logic                  par_bit;

  always_comb begin
    par_bit   = (PARITY == int'(PAR_ODD)) ? ~(^data) : ^data;
    frame     = '1;
    frame[0]  = 1'b0;
    frame[8:1] = data;
    if (HAS_PAR != 0) frame[9] = par_bit;
  end

  // Idle line is high whenever no frame is in flight, including straight out of reset.
  assign tx        = ~active_q | shift_q[0];
  assign byte_done = active_q && (cnt_q == '0) && (idx_q == IDX_LAST);

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        cnt_d    = CNT_TOP;
        idx_d    = '0;
        shift_d  = frame;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (idx_q == IDX_LAST) begin
      active_d = 1'b0;
    end else begin
      cnt_d   = CNT_TOP;
      idx_d   = idx_q + 4'd1;
      shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/uart_dec_tx.sv
// Binary value -> saturated decimal ASCII (optional zero suppression, CR/LF) -> UART line.
//   state      | meaning
//   ST_IDLE    | ready, waiting for valid
//   ST_CONVERT | double-dabble, one value bit per cycle
//   ST_LOAD    | present next message byte, pulse serialiser start
//   ST_WAIT    | wait for serialiser byte_done
module uart_dec_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int VAL_W          = 7,
  parameter int DIGITS         = 3,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int SUPPRESS_ZEROS = 1,
  parameter int APPEND_CRLF    = 1
) (
  input logic         clk,
  input logic         RST,
  uart_dec_tx_if.slave bus
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int MAX_VAL    = 10 ** DIGITS - 1;
  localparam int BCD_W      = 4 * DIGITS;
  localparam logic [2:0] LAST_IDX = 3'((APPEND_CRLF != 0) ? DIGITS + 1 : DIGITS - 1);
  localparam logic [4:0] BITS_TOP = 5'(VAL_W - 1);

  msg_state_t       state_q, state_d;
  logic [VAL_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       msg_idx_q, msg_idx_d;
  logic             done_q, done_d;

  logic [VAL_W-1:0] val_sat;
  logic [BCD_W-1:0] bcd_adj, bcd_next;
  logic [2:0]       first_idx;
  logic [3:0]       digit;
  logic [7:0]       byte_data;
  logic             start;
  logic             byte_done;
  logic             tx_line;

  always_comb begin
    val_sat = (32'(bus.value) > 32'(MAX_VAL)) ? VAL_W'(MAX_VAL) : bus.value;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = BCD_W'({bcd_adj, sh_q[VAL_W-1]});
  end

  // Most significant non-zero digit of the finished conversion; the last digit is always sent.
  always_comb begin
    first_idx = (SUPPRESS_ZEROS != 0) ? 3'(DIGITS - 1) : 3'd0;
    for (int i = 1; i < DIGITS; i++) begin
      if ((SUPPRESS_ZEROS != 0) && (bcd_next[4*i +: 4] != 4'd0)) first_idx = 3'(DIGITS - 1 - i);
    end
  end

  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (msg_idx_q == 3'(DIGITS - 1 - i)) digit = bcd_q[4*i +: 4];
    end
    if (msg_idx_q < 3'(DIGITS))       byte_data = ASCII_ZERO | {4'd0, digit};
    else if (msg_idx_q == 3'(DIGITS)) byte_data = ASCII_CR;
    else                              byte_data = ASCII_LF;
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    msg_idx_d = msg_idx_q;
    done_d    = 1'b0;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          sh_d      = val_sat;
          bcd_d     = '0;
          bit_cnt_d = BITS_TOP;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d = bcd_next;
        sh_d  = sh_q << 1;
        if (bit_cnt_q == '0) begin
          msg_idx_d = first_idx;
          state_d   = ST_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ST_LOAD: begin
        start   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (byte_done) begin
          if (msg_idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            msg_idx_d = msg_idx_q + 3'd1;
            state_d   = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      msg_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      msg_idx_q <= msg_idx_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.tx    = tx_line;

  uart_byte_tx #(
    .BIT_PERIOD (BIT_PERIOD),
    .PARITY     (PARITY),
    .STOP_BITS  (STOP_BITS)
  ) u_byte_tx (
    .clk       (clk),
    .RST       (RST),
    .start     (start),
    .data      (byte_data),
    .tx        (tx_line),
    .byte_done (byte_done)
  );

endmodule

// File: doc/uart_dec_tx.md
# uart_dec_tx

Parametrised UART transmitter for sensor telemetry. It accepts an unsigned binary value over a valid/ready handshake and converts it to decimal ASCII digits. It optionally suppresses leading zeros and appends CR/LF, then serialises each byte as a UART frame with configurable parity and stop bits. It sits between the sensor sampling logic and the board TX pin, and generalises the fixed two-digit, 7-bit temperature transmitter.

## Interface
- CLK_FREQ, 50_000_000: system clock in Hz.
- BAUD_RATE, 115200: line rate. BIT_PERIOD = CLK_FREQ/BAUD_RATE, integer division, must be ≥ 2.
- VAL_W, 7: input value width, 1–16.
- DIGITS, 3: decimal digits produced, 1–5.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- SUPPRESS_ZEROS, 1: 1 = omit leading zero digits. The least significant digit is always sent.
- APPEND_CRLF, 1: 1 = send 0x0D then 0x0A after the digits.
- clk  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- valid  in  1  value is presented.
- value  in  VAL_W  unsigned value to send.
- ready  out  1  block can accept a value; high only in IDLE.
- busy  out  1  equals !ready.
- tx  out  1  UART line, idle high.
- done  out  1  one-cycle pulse at the end of a message.

## Operation
- Reset values: ready=1, busy=0, tx=1, done=0, FSM=IDLE. All counters and registers are cleared. Assertion mid-message aborts it and drives tx high immediately, asynchronously.
- Acceptance: a value is accepted on the clock edge where valid && ready. value is latched, ready drops. valid is ignored while ready=0; there is no queueing.
- Saturation: if the latched value > 10^DIGITS−1, it is replaced by 10^DIGITS−1 (all '9').
- FSM states:
  - IDLE: on acceptance, go to CONVERT.
  - CONVERT: sequential double-dabble, one value bit per cycle, exactly VAL_W cycles, producing DIGITS BCD nibbles. Then go to LOAD.
  - LOAD: pick the next byte and issue a one-cycle start to the serialiser, then go to WAIT.
  - WAIT: stay until serialiser byte_done. Then go to LOAD if bytes remain, otherwise to IDLE with done=1 for that cycle.
- Byte order: digits from most significant to least. Each digit byte = 0x30 + BCD.
  - With SUPPRESS_ZEROS, leading zero digits are skipped up to, but excluding, the last digit.
  - If APPEND_CRLF, 0x0D then 0x0A follow.
- Serialiser frame, for each byte:
  - start bit 0;
  - 8 data bits, LSB first;
  - parity bit if PARITY≠0 (even: XOR of data; odd: its inverse);
  - STOP_BITS stop bits of 1.
- Bit timing: every bit holds exactly BIT_PERIOD cycles. The baud counter restarts at each frame start; there is no free-running phase.

## Timing
- Acceptance edge = cycle 0.
- CONVERT occupies cycles 1..VAL_W. LOAD is at cycle VAL_W+1. tx falls, first start bit, at cycle VAL_W+2.
- Frame length F = BIT_PERIOD × (10 + (PARITY≠0) + (STOP_BITS−1)) cycles.
- byte_done pulses in the last cycle of the final stop bit.
- Inter-byte gap: exactly 1 idle-high cycle (the LOAD cycle) between a stop bit and the next start bit.
- done pulses in the cycle after the last byte's byte_done, and ready=1 in that same cycle. A new value may be accepted on that edge.
- Total message: (VAL_W+2) + N×F + (N−1) cycles to the end of the last stop bit, where N is the byte count.

## Structure
- Package uart_pkg:
  - parity_t enum {PAR_NONE, PAR_EVEN, PAR_ODD};
  - constants ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function bit_period(clk_freq, baud).
- Sub-module uart_byte_tx:
  - ports clk, RST, start, data[7:0], tx, byte_done;
  - parameters BIT_PERIOD, PARITY, STOP_BITS;
  - owns the baud counter, bit index and shift register.
- The top level owns the handshake, saturation, double-dabble and message FSM.

## Test plan
Bench uses CLK_FREQ=16, BAUD_RATE=1, so BIT_PERIOD=16.
- Default parameters, value=72: line bytes 0x37, 0x32, 0x0D, 0x0A. tx falls at cycle 9. done pulses once after the last stop bit, and ready rises in that same cycle.
- value=0, SUPPRESS_ZEROS=1: bytes 0x30, 0x0D, 0x0A. With SUPPRESS_ZEROS=0 and APPEND_CRLF=0: bytes 0x30, 0x30, 0x30.
- VAL_W=10, DIGITS=3, value=1000: saturates, bytes 0x39, 0x39, 0x39, 0x0D, 0x0A.
- PARITY=1, STOP_BITS=2, value=7, APPEND_CRLF=0: single frame 0, 11101100, parity 1, 1, 1. The frame is 192 cycles.
- valid held high with a changing value while busy: only the first value is transmitted. The next value is accepted on the done cycle.
- RST asserted mid data bit: tx=1, ready=1, busy=0 without waiting for a clock edge. After release, value=5 sends 0x35 0x0D 0x0A correctly.
